// File: rtl/led_pattern_seq.sv
// LED pattern memory and sequencer: DEPTH x WIDTH register file with a
// registered read port driven by manual selection or prescaled auto stepping.
module led_pattern_seq #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    man_sel,
    input  logic [AW-1:0]    last,
    input  logic [DIV_W-1:0] tick_div,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] pat_out,
    output logic [AW-1:0]    cur_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LOOP    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [DIV_W-1:0]   count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [AW-1:0]      cur_idx_q, cur_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];

    logic               start_ok_s;
    logic               step_s;
    logic               at_last_s;
    logic [AW-1:0]      man_idx_s;
    logic [AW-1:0]      rd_idx_s;

    // Shared qualifiers for the FSM and datapath.
    always_comb begin
        start_ok_s = start && !stop && ((mode == MODE_LOOP) || (mode == MODE_ONESHOT));
        step_s     = (count_q == tick_div);
        at_last_s  = (idx_q >= last);
        // Legacy selector: 0 picks the top entry, k picks entry k-1.
        man_idx_s  = (man_sel == {AW{1'b0}}) ? AW'(DEPTH - 1) : (man_sel - AW'(1));
    end

    // Pattern memory next value: one entry replaced per write strobe.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (wr_en && (wr_addr == AW'(i))) ? wr_data : mem_q[i];
        end
    end

    // Pattern memory storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; stop always wins over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (step_s && at_last_s && (mode_q == MODE_ONESHOT)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start_ok_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer datapath: index, prescaler and latched mode.
    always_comb begin
        idx_d   = idx_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    mode_d  = mode;
                    idx_d   = {AW{1'b0}};
                    count_d = {DIV_W{1'b0}};
                end else begin
                    idx_d   = idx_q;
                    count_d = count_q;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    idx_d   = idx_q;
                    count_d = count_q;
                end else if (step_s) begin
                    count_d = {DIV_W{1'b0}};
                    if (!at_last_s) begin
                        idx_d = idx_q + AW'(1);
                    end else if (mode_q == MODE_LOOP) begin
                        idx_d = {AW{1'b0}};
                    end else begin
                        // One-shot end: hold the final entry for DONE.
                        idx_d = idx_q;
                    end
                end else begin
                    count_d = count_q + DIV_W'(1);
                end
            end
            default: begin
                idx_d   = {AW{1'b0}};
                count_d = {DIV_W{1'b0}};
            end
        endcase
    end

    // Sequencer datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= {AW{1'b0}};
            count_q <= {DIV_W{1'b0}};
            mode_q  <= 2'b00;
        end else begin
            idx_q   <= idx_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    // FSM output logic: read index selection with write-first bypass.
    always_comb begin
        case (state_q)
            ST_IDLE: rd_idx_s = man_idx_s;
            ST_RUN:  rd_idx_s = idx_q;
            ST_DONE: rd_idx_s = idx_q;
            default: rd_idx_s = man_idx_s;
        endcase
        if (wr_en && (wr_addr == rd_idx_s)) begin
            pat_d = wr_data;
        end else begin
            pat_d = mem_q[rd_idx_s];
        end
        cur_idx_d = rd_idx_s;
        busy_d    = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q     <= {WIDTH{1'b0}};
            cur_idx_q <= {AW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            cur_idx_q <= cur_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pat_out = pat_q;
    assign cur_idx = cur_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_led_pattern_seq;

    localparam int W  = 2;
    localparam int D  = 8;
    localparam int A  = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [A-1:0]  wr_addr;
    logic [W-1:0]  wr_data;
    logic [1:0]    mode;
    logic [A-1:0]  man_sel;
    logic [A-1:0]  last;
    logic [DW-1:0] tick_div;
    logic          start;
    logic          stop;
    logic [W-1:0]  pat_out;
    logic [A-1:0]  cur_idx;
    logic          busy;
    logic          done;

    led_pattern_seq #(.WIDTH(W), .DEPTH(D), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mode(mode), .man_sel(man_sel), .last(last), .tick_div(tick_div),
        .start(start), .stop(stop), .pat_out(pat_out), .cur_idx(cur_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a player that is idle, playing or finished.
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_FIN  = 2;

    int m_mem [D];
    int m_phase;
    int m_pos;
    int m_dwell;
    bit m_oneshot;
    int m_pat, m_cur;
    bit m_busy, m_done;

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_phase = M_IDLE; m_pos = 0; m_dwell = 0; m_oneshot = 1'b0;
        m_pat = 0; m_cur = 0; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        int  shown;
        bit  go;
        shown = (m_phase == M_IDLE) ? ((man_sel == 0) ? D - 1 : int'(man_sel) - 1) : m_pos;
        m_pat = (wr_en && int'(wr_addr) == shown) ? int'(wr_data) : m_mem[shown];
        m_cur = shown;
        if (wr_en) m_mem[wr_addr] = int'(wr_data);
        go = start && !stop && (mode == 2'd1 || mode == 2'd2);
        if (m_phase == M_PLAY) begin
            if (stop) begin
                m_phase = M_IDLE;
            end else if (m_dwell == int'(tick_div)) begin
                m_dwell = 0;
                if (m_pos < int'(last)) m_pos = m_pos + 1;
                else if (m_oneshot) m_phase = M_FIN;
                else m_pos = 0;
            end else begin
                m_dwell = (m_dwell + 1) % 65536;
            end
        end else if (m_phase == M_FIN && stop) begin
            m_phase = M_IDLE;
        end else if (go) begin
            m_phase = M_PLAY; m_pos = 0; m_dwell = 0; m_oneshot = (mode == 2'd2);
        end
        m_busy = (m_phase == M_PLAY);
        m_done = (m_phase == M_FIN);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("pat_out", 32'(pat_out), 32'(m_pat));
        check_eq("cur_idx", 32'(cur_idx), 32'(m_cur));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_pat", 32'(pat_out), 32'd0);
        check_eq("rst_idx", 32'(cur_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int loop_seq [10];

    initial begin
        loop_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 2'd0; mode = 2'd0;
        man_sel = 3'd0; last = 3'd0; tick_div = 16'd0; start = 1'b0; stop = 1'b0;
        #12;
        check_eq("reset_pat", 32'(pat_out), 32'd0);
        check_eq("reset_idx", 32'(cur_idx), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Manual mapping
        for (int i = 0; i < D; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 2'(i % 4);
            cycle();
        end
        wr_en = 1'b0;
        man_sel = 3'd0; cycle();
        check_eq("man0_pat", 32'(pat_out), 32'd3);
        check_eq("man0_idx", 32'(cur_idx), 32'd7);
        man_sel = 3'd3; cycle();
        check_eq("man3_pat", 32'(pat_out), 32'd2);
        check_eq("man3_idx", 32'(cur_idx), 32'd2);

        // Loop mode with two cycles per entry
        mode = 2'd1; last = 3'd3; tick_div = 16'd1; start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("loop_idx", 32'(cur_idx), 32'(loop_seq[i]));
            check_eq("loop_busy", 32'(busy), 32'd1);
        end
        stop = 1'b1; cycle(); stop = 1'b0; mode = 2'd0; cycle();
        check_eq("loop_stopped", 32'(busy), 32'd0);

        // One-shot, DONE tracking and restart
        mode = 2'd2; last = 3'd2; tick_div = 16'd0; start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("os_idx", 32'(cur_idx), 32'(i));
        end
        check_eq("os_done", 32'(done), 32'd1);
        check_eq("os_busy", 32'(busy), 32'd0);
        check_eq("os_pat", 32'(pat_out), 32'd2);
        cycle();
        check_eq("os_hold_idx", 32'(cur_idx), 32'd2);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 2'd1; cycle(); wr_en = 1'b0;
        check_eq("done_track", 32'(pat_out), 32'd1);
        start = 1'b1; cycle(); start = 1'b0;
        check_eq("restart_done", 32'(done), 32'd0);
        cycle();
        check_eq("restart_idx", 32'(cur_idx), 32'd0);
        stop = 1'b1; cycle(); stop = 1'b0;

        // Stop priority and stop mid-run
        mode = 2'd1; start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        check_eq("prio_busy", 32'(busy), 32'd0);
        last = 3'd7; tick_div = 16'd0; start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        stop = 1'b1; man_sel = 3'd5; cycle(); stop = 1'b0;
        check_eq("stop_idx", 32'(cur_idx), 32'd2);
        check_eq("stop_busy", 32'(busy), 32'd0);
        cycle();
        check_eq("resume_idx", 32'(cur_idx), 32'd4);
        check_eq("resume_pat", 32'(pat_out), 32'd0);

        // Write bypass during RUN
        mode = 2'd1; last = 3'd3; tick_div = 16'd5; start = 1'b1; cycle(); start = 1'b0;
        repeat (6) cycle();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 2'b10; cycle();
        check_eq("bypass_pat", 32'(pat_out), 32'd2);
        check_eq("bypass_idx", 32'(cur_idx), 32'd1);
        wr_addr = 3'd3; wr_data = 2'd0; cycle(); wr_en = 1'b0;
        check_eq("other_wr_pat", 32'(pat_out), 32'd2);

        // Async reset mid-run
        async_reset();
        man_sel = 3'd2; cycle();
        check_eq("post_rst_pat", 32'(pat_out), 32'd0);
        check_eq("post_rst_idx", 32'(cur_idx), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            wr_en   = ($urandom_range(3) == 0);
            wr_addr = 3'($urandom_range(7));
            wr_data = 2'($urandom_range(3));
            mode    = 2'($urandom_range(3));
            man_sel = 3'($urandom_range(7));
            last    = 3'($urandom_range(7));
            if ($urandom_range(19) == 0) tick_div = 16'($urandom_range(3));
            start   = ($urandom_range(11) == 0);
            stop    = ($urandom_range(29) == 0);
            if ($urandom_range(499) == 0) async_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
